// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control unit.
//   - genericCounter control codes (2-bit field per counter)
//   - control FSM state type
//   - bit positions of each counter field inside the 6-bit control word
package stopwatch_pkg;

    localparam logic [1:0] CTR_HOLD = 2'b00;
    localparam logic [1:0] CTR_INC  = 2'b01;
    localparam logic [1:0] CTR_LOAD = 2'b10;
    localparam logic [1:0] CTR_CLR  = 2'b11;

    typedef enum logic [1:0] {
        S_CLR  = 2'b00,
        S_STOP = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    localparam int unsigned CW_WIDTH    = 6;
    localparam int unsigned CW_PRE_LSB  = 0;  // tenth-second prescaler
    localparam int unsigned CW_TEN_LSB  = 2;  // tenths digit
    localparam int unsigned CW_UNIT_LSB = 4;  // units digit

    // Assemble a control word from its three per-counter fields.
    function automatic logic [CW_WIDTH-1:0] make_cw(
        input logic [1:0] unit_f,
        input logic [1:0] ten_f,
        input logic [1:0] pre_f
    );
        return {unit_f, ten_f, pre_f};
    endfunction

endpackage

// File: rtl/stopwatch_control_if.sv
// Control/status link between the stopwatch control unit and its datapath.
//   tenth    : prescaler count equals tenthSecondConstant
//   tenthMax : tenths digit equals 9
//   unitMax  : units digit equals 9
//   cw       : control word {units[1:0], tenths[1:0], prescaler[1:0]}
// master = control unit (drives cw), slave = datapath (drives status).
interface stopwatch_control_if;
    import stopwatch_pkg::*;

    logic                tenth;
    logic                tenthMax;
    logic                unitMax;
    logic [CW_WIDTH-1:0] cw;

    modport master (input tenth, input tenthMax, input unitMax, output cw);
    modport slave  (output tenth, output tenthMax, output unitMax, input cw);

endinterface

// File: rtl/stopwatch_control_sync_edge.sv
// button_sync_edge: synchronises a raw asynchronous button into the clk
// domain and emits a single-cycle pulse on its rising edge.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   btn   : raw button, asynchronous to clk, active-high
//   pulse : one-cycle high on each synchronised rising edge
// Parameter SYNC_STAGES (>= 2): synchroniser depth.
module button_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    // Decoded from flops only, so no raw-button path reaches the FSM.
    assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/stopwatch_control.sv
// stopwatch_control: control FSM for the stopwatch datapath.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   btnStartStop : raw start/stop button (async, active-high)
//   btnClear     : raw clear button (async, active-high)
//   dp           : datapath link (status in, control word cw out)
//   running      : high while in RUN
//   wrapped      : sticky, set on 9.9 -> 0.0 rollover, cleared by CLR
// Parameter SYNC_STAGES (>= 2): button synchroniser depth.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btnStartStop,
    input  logic                       btnClear,
    stopwatch_control_if.master        dp,
    output logic                       running,
    output logic                       wrapped
);

    logic                ss_pulse;
    logic                clr_pulse;
    state_t              state;
    state_t              state_next;
    logic [CW_WIDTH-1:0] cw_next;
    logic                rollover;

    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (btnStartStop),
        .pulse (ss_pulse)
    );

    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btnClear),
        .pulse (clr_pulse)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_CLR;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus Mealy control word. In RUN the tick word is issued
    // even when a button pulse moves the FSM out of RUN on the same edge.
    always_comb begin
        state_next = state;
        cw_next    = make_cw(CTR_HOLD, CTR_HOLD, CTR_HOLD);
        running    = 1'b0;
        case (state)
            S_CLR: begin
                cw_next    = make_cw(CTR_CLR, CTR_CLR, CTR_CLR);
                state_next = S_STOP;
            end
            S_STOP: begin
                if (clr_pulse) begin
                    state_next = S_CLR;
                end else if (ss_pulse) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                running = 1'b1;
                if (!dp.tenth) begin
                    cw_next = make_cw(CTR_HOLD, CTR_HOLD, CTR_INC);
                end else if (!dp.tenthMax) begin
                    cw_next = make_cw(CTR_HOLD, CTR_INC, CTR_CLR);
                end else if (!dp.unitMax) begin
                    cw_next = make_cw(CTR_INC, CTR_CLR, CTR_CLR);
                end else begin
                    cw_next = make_cw(CTR_CLR, CTR_CLR, CTR_CLR);
                end
                if (clr_pulse) begin
                    state_next = S_CLR;
                end else if (ss_pulse) begin
                    state_next = S_STOP;
                end
            end
            default: begin
                cw_next    = make_cw(CTR_CLR, CTR_CLR, CTR_CLR);
                state_next = S_CLR;
            end
        endcase
    end

    assign dp.cw    = cw_next;
    assign rollover = (state == S_RUN) & dp.tenth & dp.tenthMax & dp.unitMax;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrapped <= 1'b0;
        end else if (state == S_CLR) begin
            wrapped <= 1'b0;
        end else if (rollover) begin
            wrapped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_control.sv
// Self-checking bench for stopwatch_control (SYNC_STAGES = 2).
// Expectations are queued when stimulus is applied and popped when the
// outputs are sampled mid-cycle (negedge) or just after an async event.
module tb_stopwatch_control;

    logic clk;
    logic rst_n;
    logic btn_ss;
    logic btn_clr;
    logic running;
    logic wrapped;

    stopwatch_control_if dp ();

    stopwatch_control #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .btnStartStop (btn_ss),
        .btnClear     (btn_clr),
        .dp           (dp.master),
        .running      (running),
        .wrapped      (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] val;   // {cw, running, wrapped}
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic void push_exp(input string n, input logic [5:0] c,
                                     input logic r, input logic w);
        exp_t e;
        e.name = n;
        e.val  = {c, r, w};
        exp_q.push_back(e);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_status(input logic t, input logic tm, input logic um);
        dp.tenth    = t;
        dp.tenthMax = tm;
        dp.unitMax  = um;
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [7:0] obs;
        rst_n = 1'b0;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) rst_n = 1'b1;
            if (i < 4) push_exp($sformatf("reset_c%0d", i), 6'b111111, 1'b0, 1'b0);
            else       push_exp("reset_stop", 6'b000000, 1'b0, 1'b0);
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {dp.cw, running, wrapped};
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got cw=%b run=%b wr=%b, expected cw=%b run=%b wr=%b",
                         e.name, obs[7:2], obs[1], obs[0], e.val[7:2], e.val[1], e.val[0]);
            end
            next_cycle();
        end
    endtask

    task automatic test_start();
        exp_t       e;
        logic [7:0] obs;
        btn_ss = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) btn_ss = 1'b0;
            if (i >= 3) push_exp($sformatf("start_c%0d", i), 6'b000001, 1'b1, 1'b0);
            else        push_exp($sformatf("start_c%0d", i), 6'b000000, 1'b0, 1'b0);
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {dp.cw, running, wrapped};
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got cw=%b run=%b wr=%b, expected cw=%b run=%b wr=%b",
                         e.name, obs[7:2], obs[1], obs[0], e.val[7:2], e.val[1], e.val[0]);
            end
            next_cycle();
        end
    endtask

    task automatic test_tick();
        exp_t       e;
        logic [7:0] obs;
        logic       tm_t [3] = '{1'b0, 1'b1, 1'b1};
        logic       um_t [3] = '{1'b0, 1'b0, 1'b1};
        logic [5:0] cw_t [3] = '{6'b000111, 6'b011111, 6'b111111};
        for (int k = 0; k < 3; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                if (ph == 0) begin
                    set_status(1'b1, tm_t[k], um_t[k]);
                    push_exp($sformatf("tick%0d", k), cw_t[k], 1'b1, 1'b0);
                end else begin
                    set_status(1'b0, 1'b0, 1'b0);
                    push_exp($sformatf("tick%0d_after", k), 6'b000001, 1'b1, k == 2);
                end
                @(negedge clk);
                e   = exp_q.pop_front();
                obs = {dp.cw, running, wrapped};
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s: got cw=%b run=%b wr=%b, expected cw=%b run=%b wr=%b",
                             e.name, obs[7:2], obs[1], obs[0], e.val[7:2], e.val[1], e.val[0]);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_stop_collision();
        exp_t       e;
        logic [7:0] obs;
        // per cycle: button, tenth, tenthMax, unitMax, expected cw, running
        logic       b_t  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic       t_t  [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        logic       tm_t [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic       um_t [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic [5:0] cw_t [8] = '{6'b000001, 6'b000001, 6'b000111, 6'b000000,
                                 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        logic       r_t  [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            btn_ss = b_t[i];
            set_status(t_t[i], tm_t[i], um_t[i]);
            push_exp($sformatf("collide_c%0d", i), cw_t[i], r_t[i], 1'b1);
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {dp.cw, running, wrapped};
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got cw=%b run=%b wr=%b, expected cw=%b run=%b wr=%b",
                         e.name, obs[7:2], obs[1], obs[0], e.val[7:2], e.val[1], e.val[0]);
            end
            next_cycle();
        end
    endtask

    task automatic test_clear_priority();
        exp_t       e;
        logic [7:0] obs;
        // status held active to show it is ignored outside RUN
        set_status(1'b1, 1'b1, 1'b1);
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                btn_ss  = 1'b0;
                btn_clr = 1'b0;
            end
            if (i < 3)       push_exp($sformatf("clrpri_c%0d", i), 6'b000000, 1'b0, 1'b1);
            else if (i == 3) push_exp("clrpri_clr", 6'b111111, 1'b0, 1'b1);
            else             push_exp($sformatf("clrpri_c%0d", i), 6'b000000, 1'b0, 1'b0);
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {dp.cw, running, wrapped};
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got cw=%b run=%b wr=%b, expected cw=%b run=%b wr=%b",
                         e.name, obs[7:2], obs[1], obs[0], e.val[7:2], e.val[1], e.val[0]);
            end
            next_cycle();
        end
        set_status(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        exp_t       e;
        logic [7:0] obs;
        btn_ss = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) btn_ss = 1'b0;
            if (i == 6) rst_n = 1'b1;
            if (i < 3)       push_exp($sformatf("arst_c%0d", i), 6'b000000, 1'b0, 1'b0);
            else if (i < 5)  push_exp($sformatf("arst_run%0d", i), 6'b000001, 1'b1, 1'b0);
            else if (i == 5) push_exp("arst_async", 6'b111111, 1'b0, 1'b0);
            else if (i == 6) push_exp("arst_clr", 6'b111111, 1'b0, 1'b0);
            else             push_exp("arst_stop", 6'b000000, 1'b0, 1'b0);
            if (i == 5) begin
                // drop reset between edges and sample before the next edge
                @(negedge clk);
                #1 rst_n = 1'b0;
                #1;
            end else begin
                @(negedge clk);
            end
            e   = exp_q.pop_front();
            obs = {dp.cw, running, wrapped};
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got cw=%b run=%b wr=%b, expected cw=%b run=%b wr=%b",
                         e.name, obs[7:2], obs[1], obs[0], e.val[7:2], e.val[1], e.val[0]);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        set_status(1'b0, 1'b0, 1'b0);
        test_reset();
        test_start();
        test_tick();
        test_stop_collision();
        test_clear_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
